// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue controller and its helpers.
//   - ALU opcode constants (5-bit opcode space, 0..15 defined)
//   - Issue FSM state encoding
//   - Latency counter width and the largest latency it can represent
//   - Opcode class helper used by the latency lookup
package alu_issue_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDC = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBB = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_FADD = 5'd5;
  localparam logic [4:0] OP_FSUB = 5'd6;
  localparam logic [4:0] OP_FMUL = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_NAND = 5'd11;
  localparam logic [4:0] OP_NOR  = 5'd12;
  localparam logic [4:0] OP_XNOR = 5'd13;
  localparam logic [4:0] OP_NOT  = 5'd14;
  localparam logic [4:0] OP_NEG  = 5'd15;

  // The counter holds latency-1, so an 8-bit counter covers latencies 1..256.
  localparam int CNT_W   = 8;
  localparam int MAX_LAT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_INT     = 2'd0,
    CLS_MUL     = 2'd1,
    CLS_FPM     = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  // The ALU has no FP adder/subtractor, so opcodes 5 and 6 are classed as
  // illegal, as is every opcode in the upper half of the opcode space.
  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    if (op[4]) begin
      cls = CLS_ILLEGAL;
    end else begin
      case (op)
        OP_MUL:          cls = CLS_MUL;
        OP_FMUL:         cls = CLS_FPM;
        OP_FADD, OP_FSUB: cls = CLS_ILLEGAL;
        default:         cls = CLS_INT;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_lat_lookup.sv
// alu_lat_lookup
// Combinational map from ALU opcode to (latency-1, illegal). Shared by the
// issue controller and intended for reuse by hazard logic.
// Ports:
//   opcode_i   in  5      ALU opcode
//   lat_m1_o   out CNT_W  number of enable cycles minus one (0 when illegal)
//   illegal_o  out 1      opcode is unimplemented or out of range
import alu_issue_ctrl_pkg::*;

module alu_lat_lookup #(
  parameter int LAT_INT = 1,
  parameter int LAT_MUL = 4,
  parameter int LAT_FPM = 3
) (
  input  logic [4:0]       opcode_i,
  output logic [CNT_W-1:0] lat_m1_o,
  output logic             illegal_o
);

  // A zero latency would leave the ALU enabled for no cycles at all, and a
  // latency beyond MAX_LAT does not fit the counter; reject both at build time.
  if (LAT_INT < 1 || LAT_INT > MAX_LAT) begin : g_bad_lat_int
    $error("alu_lat_lookup: LAT_INT must be in 1..%0d", MAX_LAT);
  end
  if (LAT_MUL < 1 || LAT_MUL > MAX_LAT) begin : g_bad_lat_mul
    $error("alu_lat_lookup: LAT_MUL must be in 1..%0d", MAX_LAT);
  end
  if (LAT_FPM < 1 || LAT_FPM > MAX_LAT) begin : g_bad_lat_fpm
    $error("alu_lat_lookup: LAT_FPM must be in 1..%0d", MAX_LAT);
  end

  localparam logic [CNT_W-1:0] INT_M1 = CNT_W'(LAT_INT - 1);
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] FPM_M1 = CNT_W'(LAT_FPM - 1);

  always_comb begin
    lat_m1_o  = '0;
    illegal_o = 1'b0;
    case (op_class(opcode_i))
      CLS_INT: lat_m1_o = INT_M1;
      CLS_MUL: lat_m1_o = MUL_M1;
      CLS_FPM: lat_m1_o = FPM_M1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Sequencing stage in front of the 32-bit ALU. Accepts one operation over a
// valid/ready request port, holds the ALU enable for an opcode-dependent
// number of cycles, captures the ALU output and offers it downstream over a
// valid/ready result port. Illegal opcodes skip the ALU and return an error.
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid/in_ready           request handshake
//   in_opcode, in_a, in_b       request opcode and operands
//   out_valid/out_ready         result handshake
//   out_result, out_err         captured result and illegal-opcode flag
//   alu_opcode/alu_a/alu_b      registered drive to the ALU
//   alu_enable                  ALU decoder enable, high only in EXEC
//   alu_out                     ALU result, sampled in the last EXEC cycle
//   busy                        high whenever the FSM is not IDLE
import alu_issue_ctrl_pkg::*;

module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LAT_INT = 1,
  parameter int LAT_MUL = 4,
  parameter int LAT_FPM = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] lkLatM1;
  logic             lkIllegal;

  alu_lat_lookup #(
    .LAT_INT (LAT_INT),
    .LAT_MUL (LAT_MUL),
    .LAT_FPM (LAT_FPM)
  ) u_lat_lookup (
    .opcode_i  (in_opcode),
    .lat_m1_o  (lkLatM1),
    .illegal_o (lkIllegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // The ALU operand registers keep their last values outside EXEC; only
  // alu_enable tells the ALU whether to act on them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (lkIllegal) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            op_d    = in_opcode;
            a_d     = in_a;
            b_d     = in_b;
            cnt_d   = lkLatM1;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_out;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and enable outputs decode straight from the state register so
  // that reset clears them without waiting for a clock.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    alu_enable = (state_q == EXEC);
    busy       = (state_q != IDLE);
    out_result = res_q;
    out_err    = err_q;
    alu_opcode = op_q;
    alu_a      = a_q;
    alu_b      = b_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
// Directed testbench for alu_issue_ctrl. A behavioural ALU returns the true
// result only in the cycle where the enable has been high for exactly the
// opcode's latency, and a marker value at every other time.
import alu_issue_ctrl_pkg::*;

module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_enable;
  logic [31:0] alu_out;
  logic        busy;

  int compared;
  int mismatched;
  int enCnt;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_enable (alu_enable),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int benchLat(input logic [4:0] op);
    if (op == 5'd4) return 4;
    if (op == 5'd7) return 3;
    return 1;
  endfunction

  function automatic logic [31:0] aluModel(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd2:    return a - b;
      5'd4:    return a * b;
      5'd8:    return a & b;
      5'd15:   return 32'd0 - a;
      default: return a ^ b;
    endcase
  endfunction

  // Counts how many edges the enable has already been high for.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) enCnt <= 0;
    else if (alu_enable) enCnt <= enCnt + 1;
    else enCnt <= 0;
  end

  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    if (alu_enable && enCnt == benchLat(alu_opcode) - 1)
      alu_out = aluModel(alu_opcode, alu_a, alu_b);
  end

  // Presents a request at a negedge, waits for acceptance, then walks the
  // negedges until out_valid, recording enable cycles and cycles to valid.
  task automatic issueOp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int enCycles, output int valCycles, output bit readySeen);
    int guard;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    guard     = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    enCycles  = 0;
    valCycles = 0;
    readySeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      valCycles++;
      if (alu_enable) enCycles++;
      if (in_ready) readySeen = 1'b1;
      if (out_valid) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    compared++;
    if ({in_ready, out_valid, out_err, alu_enable, busy} !== 5'b10000) begin
      mismatched++;
      $display("[TB] FAIL resetCtl: got %b expected 10000",
               {in_ready, out_valid, out_err, alu_enable, busy});
    end
    compared++;
    if ({out_result, alu_opcode, alu_a, alu_b} !== '0) begin
      mismatched++;
      $display("[TB] FAIL resetData: got %h/%h/%h/%h expected all zero",
               out_result, alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_and();
    int en, vc;
    bit rs;
    out_ready = 1'b1;
    issueOp(5'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, en, vc, rs);
    compared++;
    if (en !== 1 || vc !== 2) begin
      mismatched++;
      $display("[TB] FAIL andTiming: got en=%0d valid@%0d expected en=1 valid@2", en, vc);
    end
    compared++;
    if (out_result !== 32'hF000_F000 || out_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL andResult: got %h err=%b expected f000f000 err=0", out_result, out_err);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_opcode !== 5'd8 || alu_a !== 32'hF0F0_F0F0) begin
      mismatched++;
      $display("[TB] FAIL andRelease: got valid=%b ready=%b op=%0d a=%h expected 0 1 8 f0f0f0f0",
               out_valid, in_ready, alu_opcode, alu_a);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mul();
    int en, vc;
    bit rs;
    issueOp(5'd4, 32'd7, 32'd6, en, vc, rs);
    compared++;
    if (en !== 4 || vc !== 5) begin
      mismatched++;
      $display("[TB] FAIL mulTiming: got en=%0d valid@%0d expected en=4 valid@5", en, vc);
    end
    compared++;
    if (out_result !== 32'd42 || out_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mulResult: got %0d err=%b expected 42 err=0", out_result, out_err);
    end
    compared++;
    if (rs !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL mulBusy: got readySeen=%b ready=%b busy=%b expected 0 0 1", rs, in_ready, busy);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mulRelease: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_illegal();
    int en, vc;
    bit rs;
    issueOp(5'd5, 32'd1, 32'd1, en, vc, rs);
    compared++;
    if (en !== 0 || vc !== 1) begin
      mismatched++;
      $display("[TB] FAIL illegalTiming: got en=%0d valid@%0d expected en=0 valid@1", en, vc);
    end
    compared++;
    if (out_result !== 32'd0 || out_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL illegalResult: got %h err=%b expected 0 err=1", out_result, out_err);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || alu_opcode !== 5'd4) begin
      mismatched++;
      $display("[TB] FAIL illegalRelease: got valid=%b op=%0d expected 0 4", out_valid, alu_opcode);
    end
  endtask

  task automatic test_stall();
    int en, vc;
    bit rs;
    int bad;
    issueOp(5'd0, 32'd3, 32'd4, en, vc, rs);
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'd7) begin
      mismatched++;
      $display("[TB] FAIL stallFirst: got valid=%b result=%0d expected 1 7", out_valid, out_result);
    end
    in_valid  = 1'b1;
    in_opcode = 5'd0;
    in_a      = 32'd1;
    in_b      = 32'd2;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== 32'd7 || in_ready !== 1'b0 || alu_enable !== 1'b0)
        bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("[TB] FAIL stallHold: got %0d bad cycles expected 0", bad);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stallRelease: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (alu_enable !== 1'b1 || alu_a !== 32'd1 || alu_b !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL stallAccept: got en=%b a=%0d b=%0d expected 1 1 2", alu_enable, alu_a, alu_b);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'd3) begin
      mismatched++;
      $display("[TB] FAIL stallSecond: got valid=%b result=%0d expected 1 3", out_valid, out_result);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 5'd2;
    in_a      = 32'd10;
    in_b      = 32'd3;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2bIdle: got ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    compared++;
    if (alu_enable !== 1'b1 || alu_opcode !== 5'd2) begin
      mismatched++;
      $display("[TB] FAIL b2bAccept1: got en=%b op=%0d expected 1 2", alu_enable, alu_opcode);
    end
    in_opcode = 5'd15;
    in_a      = 32'd1;
    in_b      = 32'd0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'd7 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2bResult1: got valid=%b result=%h ready=%b expected 1 7 0",
               out_valid, out_result, in_ready);
    end
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2bGap: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    compared++;
    if (alu_enable !== 1'b1 || alu_opcode !== 5'd15 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2bAccept2: got en=%b op=%0d ready=%b expected 1 15 0",
               alu_enable, alu_opcode, in_ready);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF || out_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL b2bResult2: got valid=%b result=%h err=%b expected 1 ffffffff 0",
               out_valid, out_result, out_err);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    int en, vc;
    bit rs;
    int seen;
    in_valid  = 1'b1;
    in_opcode = 5'd4;
    in_a      = 32'd5;
    in_b      = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (alu_enable !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midExecEnable: got %b expected 1", alu_enable);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({in_ready, out_valid, out_err, alu_enable, busy} !== 5'b10000 ||
        {out_result, alu_opcode, alu_a, alu_b} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midExecReset: got ctl=%b res=%h op=%0d a=%h b=%h expected 10000 and zeros",
               {in_ready, out_valid, out_err, alu_enable, busy}, out_result, alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("[TB] FAIL midExecNoValid: got %0d valid cycles expected 0", seen);
    end
    issueOp(5'd0, 32'd1, 32'd1, en, vc, rs);
    compared++;
    if (out_result !== 32'd2 || en !== 1 || out_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL postResetAdd: got %0d en=%0d err=%b expected 2 en=1 err=0",
               out_result, en, out_err);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_opcode  = '0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    test_reset();
    test_and();
    test_mul();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream sequencing stage for the 32-bit ALU.
- Accepts one operation at a time over a valid/ready request interface.
- Drives the ALU's opcode, operands and enable for an opcode-dependent number of cycles, then captures the ALU output.
- Presents the captured result downstream over a valid/ready result interface. This isolates the register file / issue logic from the ALU's mixed-latency units (integer, pipelined multiplier, FP multiplier).

Parameters:
- WIDTH, 32, operand/result width
- LAT_INT, 1, cycles enable is held for add/addc/sub/subb/logical/not/neg
- LAT_MUL, 4, cycles for integer multiply (opcode 4)
- LAT_FPM, 3, cycles for FP multiply (opcode 7)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_opcode  in  5  ALU opcode
- in_a  in  WIDTH  operand a
- in_b  in  WIDTH  operand b
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_result  out  WIDTH  captured result
- out_err  out  1  illegal/unimplemented opcode flag, qualified by out_valid
- alu_opcode  out  5  to ALU opcode
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_enable  out  1  to ALU decoder enable
- alu_out  in  WIDTH  from ALU out
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Assertion immediately forces all of the following:
  - state=IDLE, in_ready=1, out_valid=0, out_err=0
  - out_result=0, alu_enable=0, alu_opcode=0, alu_a=0, alu_b=0, busy=0
  - The latency counter is cleared.
- Reset mid-EXEC or mid-DONE abandons the operation with no result emitted.
- Opcode classes:
  - 0-3 and 8-15: LAT_INT
  - 4: LAT_MUL
  - 7: LAT_FPM
  - 5, 6 (FP add/sub, unimplemented) and 16-31: illegal
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1, alu_enable=0 (ALU outputs float).
  - On handshake with a legal opcode: register opcode/a/b onto the alu_* outputs, load counter with latency-1, go to EXEC.
  - On handshake with an illegal opcode: out_result=0, out_err=1, go directly to DONE. The ALU is never enabled.
- EXEC:
  - in_ready=0, alu_enable=1, alu_* outputs held stable.
  - Counter decrements each cycle.
  - In the cycle counter==0: capture alu_out into out_result, set out_err=0, go to DONE. alu_enable drops in the same edge.
- DONE:
  - out_valid=1; out_result and out_err held stable.
  - On out_ready: go to IDLE, out_valid=0.
  - in_ready=0 throughout DONE, so the next request is accepted no earlier than the cycle after the output handshake.
- Timing: request accepted at edge N → alu_enable high from N to N+L → out_valid high from edge N+L.
  - Minimum spacing between accepts is L+2 cycles.
- alu_a/alu_b/alu_opcode retain their last values in IDLE; only alu_enable gates the ALU.
- in_valid while not in IDLE is ignored; the request must be held until in_ready.
- out_ready asserted without out_valid has no effect.
- Latency parameters must be ≥1. A value of 0 is a configuration error, checked by an elaboration-time assertion.
- alu_out is sampled only at the terminal EXEC cycle; X/Z on alu_out at other times has no effect.

Decomposition:
- Shared package/include holds:
  - opcode constants (OP_ADD=0, OP_ADDC=1, OP_SUB=2, OP_SUBB=3, OP_MUL=4, OP_FADD=5, OP_FSUB=6, OP_FMUL=7, OP_AND=8 … OP_NEG=15)
  - state encodings (IDLE=2'd0, EXEC=2'd1, DONE=2'd2)
- One natural sub-module: alu_lat_lookup, a combinational map opcode → {latency-1, illegal}, parameterised by LAT_INT/LAT_MUL/LAT_FPM. It is reused by future hazard logic.

Test Plan:
- Reset, then AND a=0xF0F0_F0F0, b=0xFF00_FF00 with out_ready=1 → alu_enable high exactly 1 cycle; out_valid one cycle later with result 0xF000_F000, err=0.
- MUL a=7, b=6 → alu_enable high exactly 4 cycles; out_result=42; in_ready low from accept until the cycle after the output handshake.
- Opcode 5 with a=1, b=1 → alu_enable never asserted; out_valid next cycle; out_result=0, out_err=1.
- ADD 3+4 with out_ready=0 for 5 cycles → out_valid and out_result=7 held stable; a new in_valid during that time is not accepted; it is accepted the cycle after out_ready rises.
- Back-to-back SUB 10-3 then NEG 1 with in_valid held high → results 7 then 0xFFFF_FFFF in order; accepts spaced LAT_INT+2 = 3 cycles apart.
- rst_n pulled low mid-EXEC of a MUL → all outputs zero immediately and asynchronously; no out_valid after release; the next ADD 1+1 returns 2.
